// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, counter and display signals of the stopwatch controller
//
// Signals:
//   btn_start   raw start/stop button, asynchronous, active-high
//   btn_lap     raw lap/reset button, asynchronous, active-high
//   live_time   current BCD count from the counter
//   cnt_en      counter enable level (RUN/LAP)
//   cnt_tick    one-clk count pulse
//   cnt_clr     synchronous counter clear (IDLE)
//   disp_time   value routed to the seven-segment scanner
//   lap_active  display frozen (LAP)
//   state       encoded FSM state for debug/LEDs
// Modports:
//   master  the controller side
//   slave   the board/counter side

interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_lap;
  logic [23:0] live_time;
  logic        cnt_en;
  logic        cnt_tick;
  logic        cnt_clr;
  logic [23:0] disp_time;
  logic        lap_active;
  logic [1:0]  state;

  modport master (
    input  btn_start, btn_lap, live_time,
    output cnt_en, cnt_tick, cnt_clr, disp_time, lap_active, state
  );

  modport slave (
    output btn_start, btn_lap, live_time,
    input  cnt_en, cnt_tick, cnt_clr, disp_time, lap_active, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/lap sequencer with button debounce and tick prescaler
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   sw    stopwatch_ctrl_if.master: buttons and live_time in; cnt_en, cnt_tick,
//         cnt_clr, disp_time, lap_active, state out (all outputs registered)
// Parameters:
//   TICK_DIV  system clocks per count tick (2..2^24)
//   DEBOUNCE  stable synchronized samples needed to accept a button change (2..2^24)

module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_ctrl_if.master  sw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  // Button path: bit 0 = start, bit 1 = lap
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db_lvl;
  logic [1:0]    db_lvl_q;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic          start_p;
  logic          lap_p;

  assign btn_raw = {sw.btn_lap, sw.btn_start};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        // Any sample that agrees with the accepted level restarts the run.
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Only rising edges of the debounced level count as presses.
  assign press   = db_lvl & ~db_lvl_q;
  assign start_p = press[0];
  assign lap_p   = press[1];

  // FSM
  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_p) state_d = RUN;
      end
      RUN: begin
        if (start_p)    state_d = PAUSE;
        else if (lap_p) state_d = LAP;
      end
      LAP: begin
        if (start_p)    state_d = PAUSE;
        else if (lap_p) state_d = RUN;
      end
      PAUSE: begin
        if (start_p)    state_d = RUN;
        else if (lap_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic run_q;
  logic run_d;
  assign run_q = (state_q == RUN) || (state_q == LAP);
  assign run_d = (state_d == RUN) || (state_d == LAP);

  logic [PW-1:0] presc;
  logic          cnt_en_q;
  logic          cnt_tick_q;
  logic          cnt_clr_q;
  logic          lap_active_q;
  logic [23:0]   disp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      presc        <= '0;
      cnt_en_q     <= 1'b0;
      cnt_tick_q   <= 1'b0;
      cnt_clr_q    <= 1'b1;
      lap_active_q <= 1'b0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_en_q     <= run_d;
      cnt_clr_q    <= (state_d == IDLE);
      lap_active_q <= (state_d == LAP);

      // The prescaler only advances while counting continues across the
      // edge: entering RUN starts a full period, leaving it holds the
      // partial period for a later resume, and IDLE discards it.
      if (state_d == IDLE) begin
        presc <= '0;
      end else if (run_q && run_d) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      end

      cnt_tick_q <= run_q && run_d && (presc == PRESC_MAX);

      // Hold only while staying in LAP; the entry edge captures and the
      // exit edge reloads live_time.
      if (!((state_q == LAP) && (state_d == LAP))) begin
        disp_q <= sw.live_time;
      end
    end
  end

  assign sw.state      = state_q;
  assign sw.cnt_en     = cnt_en_q;
  assign sw.cnt_tick   = cnt_tick_q;
  assign sw.cnt_clr    = cnt_clr_q;
  assign sw.lap_active = lap_active_q;
  assign sw.disp_time  = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed table and sequence checks for stopwatch_ctrl (TICK_DIV=4, DEBOUNCE=3)

module tb_stopwatch_ctrl;

  logic clk;
  logic rst;
  int   errors   = 0;
  int   checks   = 0;
  int   tick_cnt = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [23:0] live;
    logic [1:0]  st;
    logic        en;
    logic        tick;
    logic        clr;
    logic        lap;
  } vec_t;

  vec_t vecs [15];
  logic [23:0] lap_live [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sw_if.cnt_tick) tick_cnt++;
    end
  endtask

  initial begin
    // start, live, state, en, tick, clr, lap
    vecs[0]  = '{1'b1, 24'h000200, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 24'h000201, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 24'h000202, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 24'h000203, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 24'h000204, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 24'h000205, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 24'h000206, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 24'h000207, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 24'h000208, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 24'h000209, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 24'h000210, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 24'h000211, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 24'h000212, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 24'h000213, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 24'h000214, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    lap_live = '{24'h000124, 24'h000125, 24'h000126, 24'h000127,
                 24'h000128, 24'h000129, 24'h000130};

    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    sw_if.live_time = 24'h000000;
    rst = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_state", 32'(sw_if.state), 0);
    chk("rst_en",    32'(sw_if.cnt_en), 0);
    chk("rst_tick",  32'(sw_if.cnt_tick), 0);
    chk("rst_clr",   32'(sw_if.cnt_clr), 1);
    chk("rst_disp",  32'(sw_if.disp_time), 0);
    chk("rst_lap",   32'(sw_if.lap_active), 0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean start press, then ticks every 4 clks; release produces nothing
    for (int i = 0; i < 15; i++) begin
      sw_if.btn_start = vecs[i].start;
      sw_if.live_time = vecs[i].live;
      step(1);
      chk($sformatf("vec%0d_state", i), 32'(sw_if.state),      32'(vecs[i].st));
      chk($sformatf("vec%0d_en", i),    32'(sw_if.cnt_en),     32'(vecs[i].en));
      chk($sformatf("vec%0d_tick", i),  32'(sw_if.cnt_tick),   32'(vecs[i].tick));
      chk($sformatf("vec%0d_clr", i),   32'(sw_if.cnt_clr),    32'(vecs[i].clr));
      chk($sformatf("vec%0d_lap", i),   32'(sw_if.lap_active), 32'(vecs[i].lap));
      chk($sformatf("vec%0d_disp", i),  32'(sw_if.disp_time),  32'(vecs[i].live));
    end

    // Pause with the prescaler at 2, then resume
    sw_if.btn_start = 1'b1;
    tick_cnt = 0;
    step(5);
    chk("pause_pre_state", 32'(sw_if.state), 1);
    chk("pause_pre_ticks", 32'(tick_cnt), 1);
    step(1);
    chk("pause_state", 32'(sw_if.state), 3);
    chk("pause_en",    32'(sw_if.cnt_en), 0);
    chk("pause_tick",  32'(sw_if.cnt_tick), 0);
    sw_if.btn_start = 1'b0;
    tick_cnt = 0;
    step(8);
    chk("pause_no_ticks",   32'(tick_cnt), 0);
    chk("pause_hold_state", 32'(sw_if.state), 3);
    sw_if.btn_start = 1'b1;
    step(5);
    chk("resume_pre_state", 32'(sw_if.state), 3);
    step(1);
    chk("resume_state", 32'(sw_if.state), 1);
    chk("resume_tick0", 32'(sw_if.cnt_tick), 0);
    step(1);
    chk("resume_tick1", 32'(sw_if.cnt_tick), 0);
    step(1);
    chk("resume_tick2", 32'(sw_if.cnt_tick), 1);
    sw_if.btn_start = 1'b0;
    step(5);

    // Lap freeze and release
    sw_if.live_time = 24'h000123;
    sw_if.btn_lap = 1'b1;
    step(5);
    chk("lap_pre_state", 32'(sw_if.state), 1);
    step(1);
    chk("lap_state",  32'(sw_if.state), 2);
    chk("lap_active", 32'(sw_if.lap_active), 1);
    chk("lap_disp",   32'(sw_if.disp_time), 'h000123);
    sw_if.btn_lap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sw_if.live_time = lap_live[i];
      step(1);
      chk($sformatf("lap_hold%0d", i), 32'(sw_if.disp_time), 'h000123);
    end
    chk("lap_hold_active", 32'(sw_if.lap_active), 1);
    chk("lap_hold_en",     32'(sw_if.cnt_en), 1);
    sw_if.btn_lap = 1'b1;
    step(5);
    chk("unlap_pre_disp", 32'(sw_if.disp_time), 'h000123);
    step(1);
    chk("unlap_state",  32'(sw_if.state), 1);
    chk("unlap_active", 32'(sw_if.lap_active), 0);
    chk("unlap_disp",   32'(sw_if.disp_time), 'h000130);
    sw_if.live_time = 24'h000131;
    step(1);
    chk("unlap_track", 32'(sw_if.disp_time), 'h000131);
    sw_if.btn_lap = 1'b0;
    step(5);

    // LAP then start -> PAUSE with live display
    sw_if.btn_lap = 1'b1;
    step(6);
    chk("l2p_lap_state", 32'(sw_if.state), 2);
    sw_if.btn_lap = 1'b0;
    sw_if.live_time = 24'h000140;
    step(5);
    chk("l2p_frozen", 32'(sw_if.disp_time), 'h000131);
    sw_if.live_time = 24'h000150;
    sw_if.btn_start = 1'b1;
    step(5);
    chk("l2p_pre_state", 32'(sw_if.state), 2);
    step(1);
    chk("l2p_state",  32'(sw_if.state), 3);
    chk("l2p_en",     32'(sw_if.cnt_en), 0);
    chk("l2p_active", 32'(sw_if.lap_active), 0);
    chk("l2p_disp",   32'(sw_if.disp_time), 'h000150);
    sw_if.live_time = 24'h000151;
    step(1);
    chk("l2p_track", 32'(sw_if.disp_time), 'h000151);

    // PAUSE + lap -> IDLE, then restart shows a full first period
    sw_if.btn_start = 1'b0;
    step(5);
    sw_if.btn_lap = 1'b1;
    step(6);
    chk("clr_state", 32'(sw_if.state), 0);
    chk("clr_clr",   32'(sw_if.cnt_clr), 1);
    chk("clr_en",    32'(sw_if.cnt_en), 0);
    sw_if.btn_lap = 1'b0;
    step(5);
    sw_if.btn_start = 1'b1;
    step(6);
    chk("restart_state", 32'(sw_if.state), 1);
    chk("restart_clr",   32'(sw_if.cnt_clr), 0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("restart_tick%0d", k), 32'(sw_if.cnt_tick), 32'(k == 4));
    end
    sw_if.btn_start = 1'b0;
    step(5);

    // Both presses together from RUN: start wins, lap dropped
    sw_if.btn_start = 1'b1;
    sw_if.btn_lap   = 1'b1;
    step(5);
    chk("prio_pre_state", 32'(sw_if.state), 1);
    step(1);
    chk("prio_state", 32'(sw_if.state), 3);
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    step(10);
    chk("prio_no_lap_state", 32'(sw_if.state), 3);
    chk("prio_no_lap_clr",   32'(sw_if.cnt_clr), 0);

    // Bouncing start button, then a stable hold gives exactly one press
    for (int c = 0; c < 20; c++) begin
      sw_if.btn_start = ((c / 2) % 2 == 0);
      step(1);
    end
    chk("bounce_state", 32'(sw_if.state), 3);
    sw_if.btn_start = 1'b1;
    step(5);
    chk("bounce_hold_pre", 32'(sw_if.state), 3);
    step(1);
    chk("bounce_hold_state", 32'(sw_if.state), 1);
    step(10);
    chk("bounce_single", 32'(sw_if.state), 1);

    // Two-clk lap glitch is rejected
    sw_if.btn_start = 1'b0;
    step(5);
    sw_if.btn_lap = 1'b1;
    step(2);
    sw_if.btn_lap = 1'b0;
    step(8);
    chk("glitch_state", 32'(sw_if.state), 1);
    chk("glitch_lap",   32'(sw_if.lap_active), 0);

    // Mid-cycle reset from LAP discards the freeze
    sw_if.live_time = 24'h000777;
    sw_if.btn_lap = 1'b1;
    step(6);
    chk("rst2_lap_state", 32'(sw_if.state), 2);
    sw_if.btn_lap = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst2_state", 32'(sw_if.state), 0);
    chk("rst2_en",    32'(sw_if.cnt_en), 0);
    chk("rst2_clr",   32'(sw_if.cnt_clr), 1);
    chk("rst2_disp",  32'(sw_if.disp_time), 0);
    chk("rst2_lap",   32'(sw_if.lap_active), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    chk("post_rst_state", 32'(sw_if.state), 0);
    chk("post_rst_clr",   32'(sw_if.cnt_clr), 1);
    chk("post_rst_disp",  32'(sw_if.disp_time), 'h000777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the BCD stopwatch counter and seven-segment display path. It debounces the start/stop and lap/reset buttons and runs a four-state run/pause/lap FSM. It generates the 10 ms count tick and the counter clear. It also selects whether the display shows the live count or a frozen lap value. It sits between the board buttons and the 24-bit BCD counter; its disp_time output feeds the seven-segment scanner.

Parameters:
TICK_DIV, 1000000, system clocks per count tick (10 ms at 100 MHz); legal range 2..2^24.
DEBOUNCE, 1000000, consecutive stable synchronized samples required to accept a button level change; legal range 2..2^24.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
btn_start  in  1  raw start/stop button, asynchronous, active-high
btn_lap  in  1  raw lap/reset button, asynchronous, active-high
live_time  in  24  current BCD count from the counter (hh:mm:ss-style nibbles)
cnt_en  out  1  counter enable level; high in RUN and LAP
cnt_tick  out  1  one-clk pulse; counter advances by one on each pulse
cnt_clr  out  1  synchronous clear to the counter; high while in IDLE
disp_time  out  24  value routed to the display
lap_active  out  1  high while the display is frozen (state LAP)
state  out  2  encoded FSM state, for debug/LEDs

Behaviour:
- Reset: clk and rst only. rst is asynchronous and active-high. Reset values:
  - state=IDLE(00), cnt_en=0, cnt_tick=0, cnt_clr=1, disp_time=24'h000000, lap_active=0.
  - Synchronizers, debounce counters, debounced levels and prescaler all cleared.
  - Reset mid-operation aborts any state immediately; a lap freeze is discarded.
- Button path, identical per button:
  - 2-FF synchronizer.
  - Debounce counter counts while the synchronized sample differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE-1 and the sample still differs, the debounced level updates and the counter clears.
  - A rising edge of the debounced level gives a one-clk press pulse (start_p / lap_p).
  - Releases produce nothing.
  - Latency from a clean raw press to the press pulse is 2+DEBOUNCE clks.
- FSM, one transition per clk, evaluated on the press pulses:
  - IDLE(00): start_p -> RUN; lap_p ignored.
  - RUN(01): start_p -> PAUSE; lap_p -> LAP (captures live_time in the same edge).
  - LAP(10): lap_p -> RUN (display returns to live); start_p -> PAUSE (display returns to live, counting stops).
  - PAUSE(11): start_p -> RUN; lap_p -> IDLE.
  - Simultaneous start_p and lap_p in the same clk: start_p wins and lap_p is dropped (not queued).
- Outputs, all registered and reflecting the next state:
  - cnt_en=1 in RUN/LAP.
  - cnt_clr=1 in IDLE only.
  - lap_active=1 in LAP only.
  - state = the encoding above.
- Prescaler (width ceil(log2 TICK_DIV)):
  - RUN/LAP: increments each clk and wraps TICK_DIV-1 -> 0. cnt_tick pulses on the clk after the prescaler equals TICK_DIV-1.
  - PAUSE: holds its value, so resume finishes the partial period.
  - IDLE: forced to 0.
  - cnt_tick is never asserted outside RUN/LAP. It is suppressed on the clk the FSM leaves RUN/LAP.
  - First tick after IDLE->RUN arrives TICK_DIV clks after the transition edge.
- disp_time:
  - Registered copy of live_time every clk (1-clk latency), except in LAP, where it holds the value captured on entry.
  - On the LAP exit edge, disp_time reloads live_time.
- No overflow handling here; BCD rollover belongs to the counter.

Test Plan:
(Bench uses TICK_DIV=4, DEBOUNCE=3.)
- Reset/start: assert rst mid-clock -> all outputs at reset values with no clk edge needed. Release rst, press btn_start clean -> state=01 at 5 clks after the press edge. cnt_clr 1->0, and cnt_tick pulses every 4 clks starting 4 clks after entry.
- Bounce rejection: toggle btn_start 1/0 every 2 clks for 20 clks, then hold 1 -> exactly one start_p, after the stable hold. A glitch of 2 clks -> no transition.
- Pause/resume: RUN, pause when the prescaler is at 2 -> no ticks in PAUSE. Resume -> first tick 2 clks after re-entering RUN (prescaler resumed from 2).
- Lap freeze: in RUN with live_time=24'h000123, press lap -> disp_time stays 000123 and lap_active=1 while live_time advances to 000130. Lap again -> disp_time tracks live one clk later and lap_active=0.
- Clear and priority: PAUSE plus btn_lap -> state=00, cnt_clr=1, prescaler 0. Press both buttons with aligned edges from RUN -> state=11 (start wins) with no later lap action.
- Lap-to-pause: LAP plus start -> state=11, cnt_en=0, disp_time = live_time on the next clk, lap_active=0.
